// File: rtl/imm_ext_pipe.sv
// Decode-stage immediate generator for every RV32 format plus CSR zimm,
// registered through a 2-entry valid/ready skid buffer with a tag sideband.
module imm_ext_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       ImmSrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  ImmExt,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    FMT_I = 3'b000,
    FMT_S = 3'b001,
    FMT_B = 3'b010,
    FMT_U = 3'b011,
    FMT_J = 3'b100,
    FMT_Z = 3'b101
  } fmt_e;

  logic [31:0]      imm32;
  logic             new_err;
  logic [XLEN-1:0]  new_imm;

  logic             main_valid;
  logic [XLEN-1:0]  main_imm;
  logic [TAG_W-1:0] main_tag;
  logic             main_err;

  logic             skid_valid;
  logic [XLEN-1:0]  skid_imm;
  logic [TAG_W-1:0] skid_tag;
  logic             skid_err;

  logic             accept;
  logic             deliver;
  logic             unused_opcode;

  // Every format is first built as a 32-bit value; Z and illegal selects
  // have bit 31 clear, so a signed widen gives the right extension for all.
  always_comb begin
    imm32   = '0;
    new_err = 1'b0;
    case (ImmSrc)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      FMT_Z:   imm32 = {27'b0, instr[19:15]};
      default: new_err = 1'b1;
    endcase
  end

  assign new_imm       = XLEN'($signed(imm32));
  assign unused_opcode = ^instr[6:0];

  assign in_ready  = !skid_valid && !reset;
  assign out_valid = main_valid && !reset;
  assign ImmExt    = main_imm;
  assign out_tag   = main_tag;
  assign out_err   = main_err;

  assign accept  = in_valid && in_ready;
  assign deliver = out_valid && out_ready;

  // Accept and deliver never coincide while skid is full, since in_ready
  // is low then; so skid only ever refills main on a plain delivery.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      main_imm   <= '0;
      main_tag   <= '0;
      main_err   <= 1'b0;
      skid_valid <= 1'b0;
      skid_imm   <= '0;
      skid_tag   <= '0;
      skid_err   <= 1'b0;
      err_cnt    <= '0;
    end else begin
      if (deliver) begin
        if (skid_valid) begin
          main_imm   <= skid_imm;
          main_tag   <= skid_tag;
          main_err   <= skid_err;
          skid_valid <= 1'b0;
        end else if (accept) begin
          main_imm <= new_imm;
          main_tag <= in_tag;
          main_err <= new_err;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (accept) begin
        if (!main_valid) begin
          main_valid <= 1'b1;
          main_imm   <= new_imm;
          main_tag   <= in_tag;
          main_err   <= new_err;
        end else begin
          skid_valid <= 1'b1;
          skid_imm   <= new_imm;
          skid_tag   <= in_tag;
          skid_err   <= new_err;
        end
      end
      if (accept && new_err && (err_cnt != {CNT_W{1'b1}})) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule
